// File: rtl/fault_map_loader_if.sv
`default_nettype none
// ============================================================================
// fault_map_loader_if : eNVM read / BISR write / status bundle for the loader
// Revision: 1.0
// ============================================================================
interface fault_map_loader_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int COUNT_WIDTH   = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
);
  logic                     load_start;
  logic                     envm_rd_en;
  logic [ADDR_WIDTH-1:0]    envm_rd_addr;
  logic [SYSTOLIC_SIZE-1:0] envm_rd_data;
  logic                     envm_wr_en;
  logic [ADDR_WIDTH-1:0]    envm_wr_addr;
  logic [SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat;
  logic                     weight_start;
  logic                     load_busy;
  logic                     load_done;
  logic [COUNT_WIDTH-1:0]   faulty_pe_count;
  logic [SYSTOLIC_SIZE-1:0] faulty_col_map;

  modport master (
    input  load_start, envm_rd_data,
    output envm_rd_en, envm_rd_addr, envm_wr_en, envm_wr_addr,
           envm_faulty_patterns_flat, weight_start, load_busy, load_done,
           faulty_pe_count, faulty_col_map
  );

  modport slave (
    output load_start, envm_rd_data,
    input  envm_rd_en, envm_rd_addr, envm_wr_en, envm_wr_addr,
           envm_faulty_patterns_flat, weight_start, load_busy, load_done,
           faulty_pe_count, faulty_col_map
  );
endinterface
`default_nettype wire

// File: rtl/fault_map_loader.sv
`default_nettype none
// ============================================================================
// fault_map_loader : replays the eNVM fault map row by row into BISR storage
// Revision: 1.0
// ============================================================================
module fault_map_loader #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int COUNT_WIDTH   = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  fault_map_loader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_rd_en;
  logic [ADDR_WIDTH-1:0]    r_rd_addr;
  logic                     r_vld;
  logic [ADDR_WIDTH-1:0]    r_vld_addr;
  logic                     r_wr_en;
  logic [ADDR_WIDTH-1:0]    r_wr_addr;
  logic [SYSTOLIC_SIZE-1:0] r_patterns;
  logic                     r_weight_start;
  logic                     r_busy;
  logic                     r_done;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [SYSTOLIC_SIZE-1:0] r_col_map;
  logic [COUNT_WIDTH-1:0]   w_pop;
  logic                     w_accept;
  logic                     w_last_rd;

  assign w_accept  = (r_state == IDLE) && bus.load_start;
  assign w_last_rd = (r_state == READ) &&
                     (r_rd_addr == ADDR_WIDTH'(SYSTOLIC_SIZE-1));

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++)
      w_pop = w_pop + COUNT_WIDTH'(bus.envm_rd_data[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // DRAIN ends once the final write is on the port and nothing is in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.load_start) w_next = READ;
      READ:    if (w_last_rd) w_next = DRAIN;
      DRAIN:   if (r_wr_en && !r_vld) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_vld          <= 1'b0;
      r_vld_addr     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_weight_start <= 1'b0;
    end else begin
      r_rd_en        <= (w_next == READ);
      if (w_accept)
        r_rd_addr <= '0;
      else if ((r_state == READ) && !w_last_rd)
        r_rd_addr <= r_rd_addr + 1'b1;
      r_vld          <= r_rd_en;
      r_vld_addr     <= r_rd_addr;
      r_busy         <= (w_next == READ) || (w_next == DRAIN);
      r_done         <= (w_next == DONE);
      r_weight_start <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_patterns <= '0;
      r_count    <= '0;
      r_col_map  <= '0;
    end else begin
      r_wr_en <= r_vld;
      if (r_vld) begin
        r_wr_addr  <= r_vld_addr;
        r_patterns <= bus.envm_rd_data;
      end
      if (w_accept) begin
        r_count   <= '0;
        r_col_map <= '0;
      end else if (r_vld) begin
        r_count   <= r_count + w_pop;
        r_col_map <= r_col_map | bus.envm_rd_data;
      end
    end
  end

  assign bus.envm_rd_en                = r_rd_en;
  assign bus.envm_rd_addr              = r_rd_addr;
  assign bus.envm_wr_en                = r_wr_en;
  assign bus.envm_wr_addr              = r_wr_addr;
  assign bus.envm_faulty_patterns_flat = r_patterns;
  assign bus.weight_start              = r_weight_start;
  assign bus.load_busy                 = r_busy;
  assign bus.load_done                 = r_done;
  assign bus.faulty_pe_count           = r_count;
  assign bus.faulty_col_map            = r_col_map;

endmodule
`default_nettype wire
